pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL provide the following ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifid_rs  in  4  source register A of the instruction in ID.
- ifid_rt  in  4  source register B of the instruction in ID.
- ifid_uses_rt  in  1  ID instruction reads ifid_rt.
- halt_id  in  1  ID instruction decodes as HALT.
- idex_memread  in  1  instruction in EX is a load.
- idex_rd  in  4  destination register of the instruction in EX.
- branch_taken  in  1  EX resolved a taken branch, call or return.
- dmem_req  in  1  MEM-stage access in progress.
- dmem_ready  in  1  data memory completes this cycle.
- wr_PC  out  1  PC register write enable.
- pc_sel  out  1  1 = load branch target, 0 = sequential PC.
- wr_IFID  out  1  IF/ID register write enable.
- IFIDflush  out  1  IF/ID synchronous clear.
- wr_IDEX  out  1  ID/EX register write enable.
- IDEXclear  out  1  ID/EX synchronous clear (bubble insert).
- wr_EXMEM  out  1  EX/MEM and MEM/WB write enable.
- halted  out  1  core stopped.
- stall_count  out  16  stall cycles since reset.

Function
REQ-002 SHALL implement FSM states RUN, DRAIN, HALTED; outputs combinational from state and inputs.
REQ-003 freeze = dmem_req & ~dmem_ready, in RUN or DRAIN: wr_PC, wr_IFID, wr_IDEX, wr_EXMEM, IFIDflush, IDEXclear, pc_sel all 0; state and drain counter hold.
REQ-004 loaduse = idex_memread & (idex_rd != 0) & ((idex_rd == ifid_rs) | (ifid_uses_rt & idex_rd == ifid_rt)).
REQ-005 RUN priority when not frozen: branch_taken > halt_id > loaduse > normal.
REQ-006 RUN, branch_taken: wr_PC=1, pc_sel=1, IFIDflush=1, IDEXclear=1, wr_EXMEM=1; halt_id and loaduse ignored; stay RUN.
REQ-007 RUN, halt_id (no branch): wr_PC=0, wr_IFID=0, IDEXclear=1, wr_EXMEM=1; next state DRAIN, drain counter = 2.
REQ-008 RUN, loaduse: wr_PC=0, wr_IFID=0, IDEXclear=1, wr_EXMEM=1; stay RUN (exactly one bubble per hazard).
REQ-009 RUN, normal: wr_PC=wr_IFID=wr_IDEX=wr_EXMEM=1; clears 0, pc_sel 0.
REQ-010 DRAIN, not frozen: wr_PC=0, wr_IFID=0, IDEXclear=1, wr_EXMEM=1; if counter==0 go HALTED, else decrement; branch_taken ignored.
REQ-011 HALTED: all write enables, clears and pc_sel 0; halted=1; exit only via reset.
REQ-012 wr_IDEX SHALL be 1 whenever IDEXclear is 1 (clear takes effect regardless).
REQ-013 stall_count SHALL increment on every RUN/DRAIN cycle with wr_PC=0 (freeze, halt, loaduse, drain); saturates at 16'hFFFF; never counts in HALTED.

Reset
REQ-014 reset low SHALL asynchronously force state RUN, drain counter 0, stall_count 0; outputs then follow RUN combinationally.
REQ-015 reset asserted mid-DRAIN or mid-freeze SHALL abandon the sequence; no residual halt.

Structure
REQ-016 State encoding, DRAIN_CYCLES=3 and the register-zero constant SHALL live in the shared pipeline package.
REQ-017 The loaduse comparator SHALL be a sub-module hazard_cmp; FSM, counters and output decode stay in pipe_hazard_ctrl.

Verification
REQ-018 Load r3 in EX (idex_rd=3), ID reads rs=3 -> one cycle wr_PC=0, IDEXclear=1, stall_count 0->1; next cycle normal.
REQ-019 idex_rd=0 with ifid_rs=0, idex_memread=1 -> no stall, stall_count unchanged.
REQ-020 branch_taken=1 with halt_id=1 and loaduse true -> pc_sel=1, IFIDflush=1, IDEXclear=1, state stays RUN, no stall count.
REQ-021 halt_id in RUN -> exactly 3 unfrozen DRAIN cycles then halted=1; stall_count +4.
REQ-022 freeze for 5 cycles during DRAIN (counter=1) -> all enables 0, counter holds, stall_count +5; halt completes 2 unfrozen cycles after release.
REQ-023 Run 70000 loaduse cycles -> stall_count saturates at 16'hFFFF; reset low mid-run -> stall_count 0, halted 0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline constants and types for the hazard/stall controller.
// Holds the controller state encoding, drain length and register-zero value.
package pipe_hazard_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   localparam int          REG_W        = 4;
   localparam int          CNT_W        = 16;
   localparam int          DRAIN_W      = 2;
   localparam int          DRAIN_CYCLES = 3;
   localparam logic [REG_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use comparator: flags when the ID instruction needs a value that the
// load currently in EX has not produced yet. Register zero never creates a hazard.
module hazard_cmp
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rd,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             ifid_uses_rt,
   output logic             loaduse
);

   logic rs_match;
   logic rt_match;

   assign rs_match = (idex_rd == ifid_rs);
   assign rt_match = ifid_uses_rt & (idex_rd == ifid_rt);
   assign loaduse  = idex_memread & (idex_rd != REG_ZERO) & (rs_match | rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory freeze, branch flush, load-use bubbles,
// HALT drain sequence and a saturating stall-cycle counter.
module pipe_hazard_ctrl
   import pipe_hazard_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] ifid_rs,
   input  logic [REG_W-1:0] ifid_rt,
   input  logic             ifid_uses_rt,
   input  logic             halt_id,
   input  logic             idex_memread,
   input  logic [REG_W-1:0] idex_rd,
   input  logic             branch_taken,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             wr_PC,
   output logic             pc_sel,
   output logic             wr_IFID,
   output logic             IFIDflush,
   output logic             wr_IDEX,
   output logic             IDEXclear,
   output logic             wr_EXMEM,
   output logic             halted,
   output logic [CNT_W-1:0] stall_count
);

   state_e             state_q, state_d;
   logic [DRAIN_W-1:0] drain_q, drain_d;
   logic [CNT_W-1:0]   stall_q, stall_d;
   logic               loaduse;
   logic               freeze;
   logic               stall;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   hazard_cmp u_cmp (
      .idex_memread (idex_memread),
      .idex_rd      (idex_rd),
      .ifid_rs      (ifid_rs),
      .ifid_rt      (ifid_rt),
      .ifid_uses_rt (ifid_uses_rt),
      .loaduse      (loaduse)
   );

   assign freeze = dmem_req & ~dmem_ready;

   always_comb begin
      state_d   = state_q;
      drain_d   = drain_q;
      stall_d   = stall_q;
      stall     = 1'b0;
      wr_PC     = 1'b0;
      pc_sel    = 1'b0;
      wr_IFID   = 1'b0;
      IFIDflush = 1'b0;
      wr_IDEX   = 1'b0;
      IDEXclear = 1'b0;
      wr_EXMEM  = 1'b0;
      halted    = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (freeze) begin
               stall = 1'b1;
            end else if (branch_taken) begin
               wr_PC     = 1'b1;
               pc_sel    = 1'b1;
               wr_IFID   = 1'b1;
               IFIDflush = 1'b1;
               wr_IDEX   = 1'b1;
               IDEXclear = 1'b1;
               wr_EXMEM  = 1'b1;
            end else if (halt_id || loaduse) begin
               // Hold IF/ID and PC, push a bubble into EX; HALT also starts the drain.
               stall     = 1'b1;
               wr_IDEX   = 1'b1;
               IDEXclear = 1'b1;
               wr_EXMEM  = 1'b1;
               if (halt_id) begin
                  state_d = ST_DRAIN;
                  drain_d = DRAIN_W'(DRAIN_CYCLES - 1);
               end
            end else begin
               wr_PC    = 1'b1;
               wr_IFID  = 1'b1;
               wr_IDEX  = 1'b1;
               wr_EXMEM = 1'b1;
            end
         end
         ST_DRAIN: begin
            stall = 1'b1;
            if (!freeze) begin
               wr_IDEX   = 1'b1;
               IDEXclear = 1'b1;
               wr_EXMEM  = 1'b1;
               if (drain_q == '0) state_d = ST_HALTED;
               else               drain_d = drain_q - 1'b1;
            end
         end
         ST_HALTED: begin
            halted = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
      if (stall) stall_d = sat_inc(stall_q);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_RUN;
         drain_q <= '0;
         stall_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
         stall_q <= stall_d;
      end
   end

   assign stall_count = stall_q;

endmodule
